// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: valid/ready pipeline register with flush and an optional 2-entry skid buffer
module wb_pipe_stage #(
    parameter int                DATA_W      = 144,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
    parameter bit                SKID        = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    logic              m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic [DATA_W-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
    logic              accept, drain;

    // Entry registers; reset drops every held beat and restores the no-op payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            m_dat_q <= NOP_PAYLOAD;
            s_dat_q <= NOP_PAYLOAD;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            m_dat_q <= m_dat_d;
            s_dat_q <= s_dat_d;
        end
    end

    // Next state: flush wins, then drain (refill M from S or input), then accept into M or S
    always_comb begin
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        if (flush) begin
            m_vld_d = 1'b0;
            m_dat_d = NOP_PAYLOAD;
            s_vld_d = 1'b0;
            s_dat_d = NOP_PAYLOAD;
        end else if (drain) begin
            if (s_vld_q) begin
                m_dat_d = s_dat_q;
                s_vld_d = 1'b0;
                s_dat_d = NOP_PAYLOAD;
            end else if (accept) begin
                m_dat_d = in_data;
            end else begin
                m_vld_d = 1'b0;
                m_dat_d = NOP_PAYLOAD;
            end
        end else if (accept) begin
            if (!m_vld_q) begin
                m_vld_d = 1'b1;
                m_dat_d = in_data;
            end else if (SKID) begin
                s_vld_d = 1'b1;
                s_dat_d = in_data;
            end
        end
    end

    // Outputs: registered in_ready with the skid entry, pass-through ready without it
    always_comb begin
        in_ready  = SKID ? !s_vld_q : (!m_vld_q || out_ready);
        out_valid = m_vld_q;
        out_data  = m_vld_q ? m_dat_q : NOP_PAYLOAD;
        occupancy = 2'(m_vld_q) + 2'(s_vld_q);
        accept    = in_valid && in_ready;
        drain     = m_vld_q && out_ready;
    end
endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb_wb_pipe_stage: scoreboard bench driving a skid and a non-skid stage with shared stimulus
module tb_wb_pipe_stage;
    localparam int          W   = 16;
    localparam logic [W-1:0] NOP = 16'hDEAD;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic [1:0]   irdy, ov;
    logic [W-1:0] od [2];
    logic [1:0]   occ [2];

    int checks = 0;
    int errs   = 0;

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic [1:0]   stall_q = 2'b00;
    logic [W-1:0] hold_q [2];

    always #5 clk = ~clk;

    wb_pipe_stage #(.DATA_W(W), .NOP_PAYLOAD(NOP), .SKID(1'b1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irdy[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0])
    );

    wb_pipe_stage #(.DATA_W(W), .NOP_PAYLOAD(NOP), .SKID(1'b0)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irdy[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1])
    );

    task automatic chk(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid)
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] q [$];
            logic         exp_rdy;
            q = (k == 0) ? q0 : q1;
            if (!reset) q.delete();
            exp_rdy = (k == 0) ? (q.size() < 2) : (q.size() == 0 || out_ready);
            chk("out_valid", k, W'(ov[k]), W'(q.size() > 0));
            chk("occupancy", k, W'(occ[k]), W'(q.size()));
            chk("out_data", k, od[k], (q.size() > 0) ? q[0] : NOP);
            chk("in_ready", k, W'(irdy[k]), W'(exp_rdy));
            if (stall_q[k] && reset) chk("stall_hold", k, od[k], hold_q[k]);
            stall_q[k] = reset && !flush && ov[k] && !out_ready;
            hold_q[k]  = od[k];
            if (reset) begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (flush) q.delete();
                else if (in_valid && exp_rdy) q.push_back(in_data);
            end
            if (k == 0) q0 = q;
            else q1 = q;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(W'(i));
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b0;
        send(16'h00A0); send(16'h00B0); send(16'h00C0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        out_ready = 1'b0;
        send(16'h0011); send(16'h0012);
        flush = 1'b1;
        send(16'h00D0);
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) step();
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        send(16'h0055); send(16'h00E0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b0;
        send(16'h0101); send(16'h0102);
        in_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        repeat (10000) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = W'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 50) == 0;
            reset     = ($urandom % 1000) != 0;
            step();
        end
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
